// File: rtl/mlp_sample_feeder.sv
// Host-side driver for the MLP classifier: packs a byte-streamed pixel sample with the bias byte,
// sequences the MLP reset/start/ready handshake and returns the label with running accuracy counters.
module mlp_sample_feeder #(
  parameter int         N_BYTES = 62,
  parameter logic [7:0] BIAS    = 8'h7F,
  parameter int         TIMEOUT = 4096,
  parameter int         CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic [7:0]             exp_label,
  output logic [8*N_BYTES+7:0]   mlp_inp,
  output logic                   mlp_rst,
  output logic                   mlp_start,
  input  logic                   mlp_ready,
  input  logic [7:0]             mlp_label,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_label,
  output logic                   res_match,
  output logic                   res_timeout,
  input  logic                   clr_stats,
  output logic [CNT_W-1:0]       total_cnt,
  output logic [CNT_W-1:0]       correct_cnt
);

  localparam int J_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [J_W-1:0]  J_LAST  = J_W'(N_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_MRST   = 3'd1,
    ST_MSTART = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [J_W-1:0]        j_r;
  logic [8*N_BYTES-1:0]  data_r;
  logic [7:0]            exp_label_r;
  logic [TO_W-1:0]       to_cnt_r;
  logic                  byte_ready_r;
  logic                  mlp_rst_r;
  logic                  mlp_start_r;
  logic                  res_valid_r;
  logic [7:0]            res_label_r;
  logic                  res_match_r;
  logic                  res_timeout_r;
  logic [CNT_W-1:0]      total_r;
  logic [CNT_W-1:0]      correct_r;

  logic                  byte_ready_nxt_s;
  logic                  mlp_rst_nxt_s;
  logic                  mlp_start_nxt_s;
  logic                  res_valid_nxt_s;
  logic                  xfer_s;
  logic                  last_xfer_s;
  logic                  ready_hit_s;
  logic                  expire_s;
  logic                  finish_s;
  logic                  match_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Handshake qualifiers; byte_ready_r is only ever high in LOAD.
  always_comb begin
    xfer_s      = byte_valid & byte_ready_r;
    last_xfer_s = xfer_s & (j_r == J_LAST);
    ready_hit_s = (state_r == ST_WAIT) & mlp_ready;
    expire_s    = (state_r == ST_WAIT) & ~mlp_ready & (to_cnt_r == TO_LAST);
    finish_s    = ready_hit_s | expire_s;
    match_nxt_s = ready_hit_s & (mlp_label == exp_label_r);
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (last_xfer_s) begin
          state_nxt_s = ST_MRST;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_MRST:   state_nxt_s = ST_MSTART;
      ST_MSTART: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (finish_s) begin
          state_nxt_s = ST_RESULT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_RESULT;
        end
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Control outputs decoded from the next state so they can be registered without a cycle of lag.
  always_comb begin
    byte_ready_nxt_s = 1'b0;
    mlp_rst_nxt_s    = 1'b0;
    mlp_start_nxt_s  = 1'b0;
    res_valid_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_LOAD:   byte_ready_nxt_s = 1'b1;
      ST_MRST:   mlp_rst_nxt_s    = 1'b1;
      ST_MSTART: mlp_start_nxt_s  = 1'b1;
      ST_WAIT:   res_valid_nxt_s  = 1'b0;
      ST_RESULT: res_valid_nxt_s  = 1'b1;
      default:   byte_ready_nxt_s = 1'b0;
    endcase
  end

  // State register and registered control outputs; the MLP is held in reset while we are.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_LOAD;
      byte_ready_r <= 1'b0;
      mlp_rst_r    <= 1'b1;
      mlp_start_r  <= 1'b0;
      res_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      byte_ready_r <= byte_ready_nxt_s;
      mlp_rst_r    <= mlp_rst_nxt_s;
      mlp_start_r  <= mlp_start_nxt_s;
      res_valid_r  <= res_valid_nxt_s;
    end
  end

  // Byte index and sample packing; the expected label is taken with the final byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_r         <= '0;
      data_r      <= '0;
      exp_label_r <= 8'h00;
    end else if (xfer_s) begin
      for (int i = 0; i < N_BYTES; i++) begin
        if (j_r == J_W'(i)) begin
          data_r[8*i +: 8] <= byte_in;
        end
      end
      if (last_xfer_s) begin
        j_r         <= '0;
        exp_label_r <= exp_label;
      end else begin
        j_r <= j_r + J_W'(1);
      end
    end
  end

  // WAIT watchdog, armed while the start pulse is out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_MSTART) begin
      to_cnt_r <= '0;
    end else if ((state_r == ST_WAIT) && !mlp_ready && !expire_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Result capture; held untouched through RESULT until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_label_r   <= 8'h00;
      res_match_r   <= 1'b0;
      res_timeout_r <= 1'b0;
    end else if (finish_s) begin
      res_label_r   <= ready_hit_s ? mlp_label : 8'hFF;
      res_match_r   <= match_nxt_s;
      res_timeout_r <= expire_s;
    end
  end

  // Saturating accuracy counters; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_r   <= '0;
      correct_r <= '0;
    end else if (clr_stats) begin
      total_r   <= '0;
      correct_r <= '0;
    end else if (finish_s) begin
      total_r <= sat_inc(total_r);
      if (match_nxt_s) begin
        correct_r <= sat_inc(correct_r);
      end
    end
  end

  assign byte_ready  = byte_ready_r;
  assign mlp_inp     = {BIAS, data_r};
  assign mlp_rst     = mlp_rst_r;
  assign mlp_start   = mlp_start_r;
  assign res_valid   = res_valid_r;
  assign res_label   = res_label_r;
  assign res_match   = res_match_r;
  assign res_timeout = res_timeout_r;
  assign total_cnt   = total_r;
  assign correct_cnt = correct_r;

endmodule

// File: tb/tb_mlp_sample_feeder.sv
// Randomized bench for mlp_sample_feeder: drives byte samples with gaps, plays a simple MLP
// that answers after a chosen delay (or never), and compares against a sample-level reference.
module tb_mlp_sample_feeder;

  localparam int NB = 62;
  localparam int TO = 16;
  localparam int W  = 8*NB + 8;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     byte_in;
  logic           byte_valid;
  logic           byte_ready;
  logic [7:0]     exp_label;
  logic [W-1:0]   mlp_inp;
  logic           mlp_rst;
  logic           mlp_start;
  logic           mlp_ready;
  logic [7:0]     mlp_label;
  logic           res_valid;
  logic           res_ready;
  logic [7:0]     res_label;
  logic           res_match;
  logic           res_timeout;
  logic           clr_stats;
  logic [CW-1:0]  total_cnt;
  logic [CW-1:0]  correct_cnt;

  int             n_tests = 0;
  int             n_fail  = 0;
  int             m_total = 0;
  int             m_correct = 0;
  logic [7:0]     bytes [NB];

  mlp_sample_feeder #(.N_BYTES(NB), .BIAS(8'h7F), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .exp_label(exp_label), .mlp_inp(mlp_inp),
    .mlp_rst(mlp_rst), .mlp_start(mlp_start), .mlp_ready(mlp_ready), .mlp_label(mlp_label),
    .res_valid(res_valid), .res_ready(res_ready), .res_label(res_label),
    .res_match(res_match), .res_timeout(res_timeout),
    .clr_stats(clr_stats), .total_cnt(total_cnt), .correct_cnt(correct_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  // Push n bytes with random gaps; exp_label carries junk except alongside the last byte.
  task automatic send_bytes(input int n, input logic [7:0] elbl);
    for (int i = 0; i < n; i++) begin
      bit done;
      int tries;
      done  = 1'b0;
      tries = 0;
      while (!done) begin
        @(negedge clk);
        byte_in    = bytes[i];
        exp_label  = (i == NB-1) ? elbl : 8'($urandom);
        byte_valid = ($urandom_range(0, 3) != 0);
        if (byte_valid && byte_ready) done = 1'b1;
        tries++;
        if (!done && tries > 50) begin
          check_eq("byte_ready_stuck", W'(byte_ready), W'(1));
          done = 1'b1;
        end
      end
    end
  endtask

  // One full sample: MLP answers d cycles after seeing start (d > TO means never in time).
  task automatic run_sample(input logic [7:0] elbl, input logic [7:0] mlbl, input int d,
                            input bit clr_at_end, input int hold);
    logic [W-1:0] vec;
    bit           tmo;
    bit           match;
    bit           seen;
    int           lat;
    vec = '0;
    vec[W-1 -: 8] = 8'h7F;
    for (int i = 0; i < NB; i++) vec[8*i +: 8] = bytes[i];
    send_bytes(NB, elbl);
    @(negedge clk);
    byte_valid = 1'b0;
    exp_label  = ~elbl;
    check_eq("mlp_inp", mlp_inp, vec);
    check_eq("mrst_pulse", W'(mlp_rst), W'(1));
    check_eq("start_early", W'(mlp_start), W'(0));
    check_eq("byte_ready_busy", W'(byte_ready), W'(0));
    @(negedge clk);
    check_eq("mrst_end", W'(mlp_rst), W'(0));
    check_eq("start_pulse", W'(mlp_start), W'(1));
    tmo = (d > TO);
    lat = (tmo ? TO : d) + 1;
    seen = 1'b0;
    for (int k = 1; k <= TO + 6 && !seen; k++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        check_eq("latency", W'(k), W'(lat));
      end else begin
        if (k == 2) check_eq("start_end", W'(mlp_start), W'(0));
        if (k == d) begin
          mlp_ready = 1'b1;
          mlp_label = mlbl;
        end
        if (k == lat - 1) clr_stats = clr_at_end;
      end
    end
    if (!seen) check_eq("res_valid_never", W'(res_valid), W'(1));
    mlp_ready = 1'b0;
    clr_stats = 1'b0;
    match = !tmo && (mlbl == elbl);
    if (clr_at_end) begin
      m_total   = 0;
      m_correct = 0;
    end else begin
      m_total = sat(m_total);
      if (match) m_correct = sat(m_correct);
    end
    check_eq("res_label", W'(res_label), W'(tmo ? 8'hFF : mlbl));
    check_eq("res_match", W'(res_match), W'(match));
    check_eq("res_timeout", W'(res_timeout), W'(tmo));
    check_eq("total_cnt", W'(total_cnt), W'(m_total));
    check_eq("correct_cnt", W'(correct_cnt), W'(m_correct));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", W'(res_valid), W'(1));
      check_eq("hold_label", W'(res_label), W'(tmo ? 8'hFF : mlbl));
      check_eq("hold_match", W'(res_match), W'(match));
      check_eq("hold_no_byte_ready", W'(byte_ready), W'(0));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("res_valid_drop", W'(res_valid), W'(0));
    check_eq("byte_ready_back", W'(byte_ready), W'(1));
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
  endtask

  initial begin
    logic [W-1:0] rvec;
    logic [7:0]   e;
    rst = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; exp_label = 8'h00;
    mlp_ready = 1'b0; mlp_label = 8'h00; res_ready = 1'b0; clr_stats = 1'b0;
    rvec = '0;
    rvec[W-1 -: 8] = 8'h7F;
    repeat (3) @(negedge clk);
    check_eq("rst_mlp_rst", W'(mlp_rst), W'(1));
    check_eq("rst_byte_ready", W'(byte_ready), W'(0));
    check_eq("rst_start", W'(mlp_start), W'(0));
    check_eq("rst_res_valid", W'(res_valid), W'(0));
    check_eq("rst_res_label", W'(res_label), W'(0));
    check_eq("rst_total", W'(total_cnt), W'(0));
    check_eq("rst_correct", W'(correct_cnt), W'(0));
    check_eq("rst_mlp_inp", mlp_inp, rvec);
    rst = 1'b1;
    #1;
    check_eq("rel_byte_ready_0", W'(byte_ready), W'(0));
    @(negedge clk);
    check_eq("rel_byte_ready_1", W'(byte_ready), W'(1));
    check_eq("rel_mlp_rst", W'(mlp_rst), W'(0));

    for (int i = 0; i < NB; i++) bytes[i] = 8'(i);
    run_sample(8'd5, 8'd5, 10, 1'b0, 5);
    rand_bytes();
    run_sample(8'd7, 8'd3, 3, 1'b0, 0);
    rand_bytes();
    run_sample(8'($urandom), 8'h00, 1000, 1'b0, 2);
    rand_bytes();
    run_sample(8'd9, 8'd9, TO, 1'b0, 1);
    rand_bytes();
    run_sample(8'd9, 8'd9, TO + 1, 1'b0, 0);

    for (int s = 0; s < 16; s++) begin
      rand_bytes();
      e = 8'($urandom);
      run_sample(e, ($urandom_range(0, 1) != 0) ? e : e ^ 8'($urandom_range(1, 255)),
                 int'($urandom_range(1, TO + 3)), 1'b0, int'($urandom_range(0, 3)));
    end

    // Abort mid-sample with reset; the next sample must need every byte again.
    rand_bytes();
    send_bytes(30, 8'h00);
    @(negedge clk);
    byte_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("abort_mlp_rst", W'(mlp_rst), W'(1));
    check_eq("abort_byte_ready", W'(byte_ready), W'(0));
    check_eq("abort_total", W'(total_cnt), W'(0));
    m_total = 0;
    m_correct = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_byte_ready_back", W'(byte_ready), W'(1));
    rand_bytes();
    run_sample(8'd42, 8'd42, 4, 1'b0, 0);
    rand_bytes();
    run_sample(8'd1, 8'd1, 6, 1'b0, 0);

    rand_bytes();
    run_sample(8'd2, 8'd2, 5, 1'b1, 0);
    rand_bytes();
    run_sample(8'd3, 8'd3, 2, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
